// File: rtl/pdp8_trace_pkg.sv
// Shared constants for the pdp8 instruction-trace recorder: capture modes,
// FSM encoding and the bit layout of one trace entry.
package pdp8_trace_pkg;

   localparam logic [1:0] TRC_FREE = 2'd0;
   localparam logic [1:0] TRC_FULL = 2'd1;
   localparam logic [1:0] TRC_TRIG = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_POST = 2'd2,
      ST_DONE = 2'd3
   } trc_state_e;

   localparam int unsigned WORD_W    = 12;
   localparam int unsigned PC_LSB    = 0;
   localparam int unsigned IR_LSB    = 12;
   localparam int unsigned LINK_BIT  = 24;
   localparam int unsigned AC_LSB    = 25;
   localparam int unsigned ION_BIT   = 37;
   localparam int unsigned STAMP_LSB = 38;

endpackage

// File: rtl/pdp8_trace_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// with read-first behaviour on a same-address collision.
module pdp8_trace_ram #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned WIDTH  = 54
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Output register carries the reset so the readout is 0 out of reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/pdp8_trace.sv
// Instruction-trace recorder: captures PC/IR/L/AC/ION and a fetch stamp on every
// fetch strobe into a circular buffer, with free-run, stop-on-full and PC-trigger modes.
module pdp8_trace
   import pdp8_trace_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned ADDR_W  = $clog2(DEPTH),
   parameter int unsigned CYC_W   = 16,
   parameter int unsigned ENTRY_W = 38 + CYC_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               arm,
   input  logic [1:0]         mode,
   input  logic [11:0]        trig_pc,
   input  logic [ADDR_W-1:0]  post_count,
   input  logic               fetch,
   input  logic [11:0]        pc,
   input  logic [11:0]        ir,
   input  logic [11:0]        ac,
   input  logic               link,
   input  logic               ion,
   input  logic               halt,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [ENTRY_W-1:0] rd_data,
   output logic [ADDR_W:0]    count,
   output logic               busy,
   output logic               done,
   output logic               triggered,
   output logic               wrapped
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam int unsigned STAMP_W = (CYC_W > 0) ? CYC_W : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

   trc_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [STAMP_W-1:0] stamp_q, stamp_d;
   logic [ADDR_W-1:0]  remain_q, remain_d;
   logic [ADDR_W-1:0]  post_q, post_d;
   logic [11:0]        trig_pc_q, trig_pc_d;
   logic [1:0]         mode_q, mode_d;
   logic               wrapped_q, wrapped_d;
   logic               triggered_q, triggered_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wr_en_c;
   logic [ADDR_W-1:0]  rd_phys_c;
   logic [37:0]        entry_base_c;
   logic [ENTRY_W-1:0] entry_c;

   always_comb begin
      entry_base_c                       = '0;
      entry_base_c[PC_LSB +: WORD_W]     = pc;
      entry_base_c[IR_LSB +: WORD_W]     = ir;
      entry_base_c[LINK_BIT]             = link;
      entry_base_c[AC_LSB +: WORD_W]     = ac;
      entry_base_c[ION_BIT]              = ion;
   end

   if (CYC_W > 0) begin : g_stamp
      assign entry_c = {stamp_q, entry_base_c};
   end else begin : g_no_stamp
      assign entry_c = entry_base_c;
   end

   // Once wrapped, the write pointer addresses the oldest surviving entry.
   assign rd_phys_c = (wrapped_q ? wr_ptr_q : '0) + rd_addr;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      stamp_d     = stamp_q;
      remain_d    = remain_q;
      post_d      = post_q;
      trig_pc_d   = trig_pc_q;
      mode_d      = mode_q;
      wrapped_d   = wrapped_q;
      triggered_d = triggered_q;
      wr_en_c     = 1'b0;

      if (arm) begin
         wr_ptr_d    = '0;
         count_d     = '0;
         stamp_d     = '0;
         wrapped_d   = 1'b0;
         triggered_d = 1'b0;
         remain_d    = '0;
         mode_d      = (mode == TRC_FULL || mode == TRC_TRIG) ? mode : TRC_FREE;
         trig_pc_d   = trig_pc;
         post_d      = post_count;
         state_d     = ST_RUN;
      end else if (state_q == ST_RUN || state_q == ST_POST) begin
         if (fetch) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            stamp_d  = stamp_q + STAMP_W'(1);
            if (count_q == FULL_CNT) begin
               wrapped_d = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end

            if (mode_q == TRC_FULL && count_q == LAST_CNT) begin
               state_d = ST_DONE;
            end

            if (mode_q == TRC_TRIG) begin
               if (state_q == ST_RUN && pc == trig_pc_q) begin
                  triggered_d = 1'b1;
                  remain_d    = post_q;
                  state_d     = (post_q == '0) ? ST_DONE : ST_POST;
               end else if (state_q == ST_POST) begin
                  remain_d = remain_q - ADDR_W'(1);
                  if (remain_q == ADDR_W'(1)) begin
                     state_d = ST_DONE;
                  end
               end
            end

            if (halt) begin
               state_d = ST_DONE;
            end
         end else if (halt) begin
            state_d = ST_DONE;
         end
      end

      busy_d = (state_d == ST_RUN) || (state_d == ST_POST);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         stamp_q     <= '0;
         remain_q    <= '0;
         post_q      <= '0;
         trig_pc_q   <= '0;
         mode_q      <= TRC_FREE;
         wrapped_q   <= 1'b0;
         triggered_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         stamp_q     <= stamp_d;
         remain_q    <= remain_d;
         post_q      <= post_d;
         trig_pc_q   <= trig_pc_d;
         mode_q      <= mode_d;
         wrapped_q   <= wrapped_d;
         triggered_q <= triggered_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   pdp8_trace_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en_c),
      .wr_addr (wr_ptr_q),
      .wr_data (entry_c),
      .rd_addr (rd_phys_c),
      .rd_data (rd_data)
   );

   assign count     = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign triggered = triggered_q;
   assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_pdp8_trace.sv
// Directed bench for pdp8_trace with DEPTH=16: capture modes, halt, arm collision, reset.
module tb_pdp8_trace;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned CYC_W   = 16;
   localparam int unsigned ENTRY_W = 54;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               arm;
   logic [1:0]         mode;
   logic [11:0]        trig_pc;
   logic [ADDR_W-1:0]  post_count;
   logic               fetch;
   logic [11:0]        pc, ir, ac;
   logic               link, ion, halt;
   logic [ADDR_W-1:0]  rd_addr;
   logic [ENTRY_W-1:0] rd_data;
   logic [ADDR_W:0]    count;
   logic               busy, done, triggered, wrapped;

   int checks = 0;
   int errors = 0;
   logic [ENTRY_W-1:0] ent;

   pdp8_trace #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CYC_W(CYC_W), .ENTRY_W(ENTRY_W)) dut (
      .clk(clk), .reset_n(reset_n), .arm(arm), .mode(mode), .trig_pc(trig_pc),
      .post_count(post_count), .fetch(fetch), .pc(pc), .ir(ir), .ac(ac),
      .link(link), .ion(ion), .halt(halt), .rd_addr(rd_addr), .rd_data(rd_data),
      .count(count), .busy(busy), .done(done), .triggered(triggered), .wrapped(wrapped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [1:0] m, input logic [11:0] t, input logic [3:0] pcnt);
      arm = 1'b1; mode = m; trig_pc = t; post_count = pcnt;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_fetch(input logic [11:0] p, input logic h);
      fetch = 1'b1; pc = p; ir = ~p; ac = p + 12'd1; link = p[0]; ion = 1'b1; halt = h;
      tick();
      fetch = 1'b0; halt = 1'b0;
   endtask

   task automatic rd(input int a, output logic [ENTRY_W-1:0] d);
      rd_addr = 4'(a);
      tick();
      d = rd_data;
   endtask

   initial begin
      reset_n = 1'b0; arm = 1'b0; mode = 2'd0; trig_pc = '0; post_count = '0;
      fetch = 1'b0; pc = '0; ir = '0; ac = '0; link = 1'b0; ion = 1'b0; halt = 1'b0;
      rd_addr = '0;
      tick(); tick();
      chk("rst_count", 32'(count), 0);
      chk("rst_flags", {busy, done, triggered, wrapped}, 0);
      chk("rst_rd_data", 32'(rd_data[31:0]), 0);
      reset_n = 1'b1;
      do_fetch(12'o100, 1'b0);
      chk("idle_ignores_fetch", 32'(count), 0);

      // Mode 0: 20 fetches into 16 entries
      do_arm(2'd0, 12'o0, 4'd0);
      chk("m0_busy_after_arm", {busy, done}, 2'b10);
      for (int n = 0; n < 20; n++) do_fetch(12'o200 + 12'(n), 1'b0);
      chk("m0_count", 32'(count), 16);
      chk("m0_wrapped", {wrapped, busy, done}, 3'b110);
      rd(0, ent);
      chk("m0_oldest_pc", 32'(ent[11:0]), 32'o204);
      chk("m0_oldest_stamp", 32'(ent[53:38]), 4);
      chk("m0_oldest_ac", 32'(ent[36:25]), 32'o205);
      rd(15, ent);
      chk("m0_newest_pc", 32'(ent[11:0]), 32'o223);
      chk("m0_newest_stamp", 32'(ent[53:38]), 19);

      // Mode 1: stop on full
      do_arm(2'd1, 12'o0, 4'd0);
      chk("m1_cleared", {27'(count), busy, done, triggered, wrapped}, 32'b01000);
      for (int n = 0; n < 15; n++) do_fetch(12'o200 + 12'(n), 1'b0);
      chk("m1_not_done_15", {busy, done}, 2'b10);
      do_fetch(12'o217, 1'b0);
      chk("m1_done_16", {busy, done}, 2'b01);
      for (int n = 16; n < 20; n++) do_fetch(12'o200 + 12'(n), 1'b0);
      chk("m1_count", 32'(count), 16);
      chk("m1_no_wrap", 32'(wrapped), 0);
      rd(15, ent);
      chk("m1_last_stamp", 32'(ent[53:38]), 15);
      chk("m1_last_pc", 32'(ent[11:0]), 32'o217);
      rd(0, ent);
      chk("m1_first_kept_pc", 32'(ent[11:0]), 32'o200);

      // Mode 2: trigger at 0207, three post-trigger fetches
      do_arm(2'd2, 12'o207, 4'd3);
      for (int n = 0; n < 7; n++) do_fetch(12'o200 + 12'(n), 1'b0);
      chk("m2_pre_trig", {busy, done, triggered}, 3'b100);
      do_fetch(12'o207, 1'b0);
      chk("m2_trig", {busy, done, triggered}, 3'b101);
      do_fetch(12'o210, 1'b0);
      do_fetch(12'o211, 1'b0);
      chk("m2_post_not_done", {busy, done}, 2'b10);
      do_fetch(12'o212, 1'b0);
      chk("m2_done", {busy, done, triggered}, 3'b011);
      chk("m2_count", 32'(count), 11);
      do_fetch(12'o207, 1'b0);
      chk("m2_second_pass_ignored", 32'(count), 11);
      rd(7, ent);
      chk("m2_trig_pc", 32'(ent[11:0]), 32'o207);
      chk("m2_trig_stamp", 32'(ent[53:38]), 7);

      // Mode 2 with post_count 0: trigger entry ends capture
      do_arm(2'd2, 12'o300, 4'd0);
      do_fetch(12'o277, 1'b0);
      do_fetch(12'o300, 1'b0);
      chk("m2_post0", {27'(count), busy, done, triggered, wrapped}, {27'd2, 4'b0110});

      // Halt with fetch, then halt alone
      do_arm(2'd0, 12'o0, 4'd0);
      do_fetch(12'o400, 1'b0);
      do_fetch(12'o401, 1'b0);
      do_fetch(12'o402, 1'b1);
      chk("halt_fetch", {27'(count), busy, done}, {27'd3, 2'b01});
      do_fetch(12'o403, 1'b0);
      chk("halt_frozen", 32'(count), 3);
      rd(2, ent);
      chk("halt_entry", {ent[53:38], ent[11:0]}, {16'd2, 12'o402});
      do_arm(2'd0, 12'o0, 4'd0);
      do_fetch(12'o410, 1'b0);
      do_fetch(12'o411, 1'b0);
      halt = 1'b1; tick(); halt = 1'b0;
      chk("halt_alone", {27'(count), busy, done}, {27'd2, 2'b01});

      // arm + fetch in the same cycle mid-capture
      do_arm(2'd0, 12'o0, 4'd0);
      for (int n = 0; n < 5; n++) do_fetch(12'o200 + 12'(n), 1'b0);
      chk("col_count5", 32'(count), 5);
      arm = 1'b1; mode = 2'd0;
      do_fetch(12'o777, 1'b0);
      arm = 1'b0;
      chk("col_cleared", {27'(count), busy, done}, {27'd0, 2'b10});
      do_fetch(12'o500, 1'b0);
      chk("col_count1", 32'(count), 1);
      rd(0, ent);
      chk("col_entry", {ent[53:38], ent[11:0]}, {16'd0, 12'o500});

      // Reset during POST
      do_arm(2'd2, 12'o200, 4'd10);
      do_fetch(12'o200, 1'b0);
      chk("rstpost_in_post", {busy, triggered}, 2'b11);
      reset_n = 1'b0; tick();
      chk("rstpost_count", 32'(count), 0);
      chk("rstpost_flags", {busy, done, triggered, wrapped}, 0);
      chk("rstpost_rd_data", 32'(rd_data[31:0]), 0);
      reset_n = 1'b1;
      do_fetch(12'o201, 1'b0);
      chk("rstpost_ignored", {27'(count), busy, done}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
